// File: rtl/lift_stepper.sv
// lift_stepper
//
// Per-car motion stepper. Turns the scheduler's requested direction into
// one-floor moves of fixed length, each followed by a fixed dwell. The dwell
// can be extended by an open door. Emergency stop pauses the current phase.
// Bad requests are reported as one-cycle error pulses with a cause code.
//
// Parameters:
//   NUM_FLOORS  - floors in the shaft, numbered 1..NUM_FLOORS
//   FLOOR_W     - floor-number width, 2**FLOOR_W > NUM_FLOORS
//   MOVE_CYCLES - cycles move stays high per step (>= 1)
//   HOLD_CYCLES - dwell cycles after a step or door event (>= 1)
//   CNT_W       - phase counter width
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high reset
//   door_open  in   door not fully closed
//   estop      in   emergency stop, level-sensitive
//   cur_floor  in   floor reported by the tracker
//   dir        in   requested direction: 00 STOP, 10 UP, 01 DOWN, 11 illegal
//   next_floor out  step target while move=1, otherwise resting floor
//   move       out  motor command, high during a step
//   busy       out  high whenever the stepper is not idle
//   err        out  one-cycle error pulse
//   err_code   out  01 UP at top, 10 DOWN at bottom, 11 illegal dir/floor

module lift_stepper #(
    parameter int NUM_FLOORS  = 7,
    parameter int FLOOR_W     = 3,
    parameter int MOVE_CYCLES = 100,
    parameter int HOLD_CYCLES = 10,
    parameter int CNT_W       = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               door_open,
    input  logic               estop,
    input  logic [FLOOR_W-1:0] cur_floor,
    input  logic [1:0]         dir,
    output logic [FLOOR_W-1:0] next_floor,
    output logic               move,
    output logic               busy,
    output logic               err,
    output logic [1:0]         err_code
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MOVE = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [1:0] DIR_STOP = 2'b00;
    localparam logic [1:0] DIR_UP   = 2'b10;
    localparam logic [1:0] DIR_DOWN = 2'b01;

    localparam logic [1:0] CODE_NONE    = 2'b00;
    localparam logic [1:0] CODE_TOP     = 2'b01;
    localparam logic [1:0] CODE_BOTTOM  = 2'b10;
    localparam logic [1:0] CODE_ILLEGAL = 2'b11;

    localparam logic [FLOOR_W-1:0] TOP_FLOOR    = FLOOR_W'(NUM_FLOORS);
    localparam logic [FLOOR_W-1:0] BOTTOM_FLOOR = FLOOR_W'(1);
    localparam logic [CNT_W-1:0]   MOVE_LOAD    = CNT_W'(MOVE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   HOLD_LOAD    = CNT_W'(HOLD_CYCLES - 1);

    // Registered state and outputs
    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [FLOOR_W-1:0] floor_q;
    logic               move_q;
    logic               busy_q;
    logic               err_q;
    logic [1:0]         code_q;

    // Next values
    state_t             state_n;
    logic [CNT_W-1:0]   cnt_n;
    logic [FLOOR_W-1:0] floor_n;
    logic               move_n;
    logic               err_n;
    logic [1:0]         code_n;

    logic floor_bad;
    logic cnt_zero;

    assign floor_bad = (cur_floor == '0) || (cur_floor > TOP_FLOOR);
    assign cnt_zero  = (cnt_q == '0);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            floor_q <= BOTTOM_FLOOR;
            move_q  <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= CODE_NONE;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            floor_q <= floor_n;
            move_q  <= move_n;
            // busy follows the next state so it rises together with move
            busy_q  <= (state_n != IDLE);
            err_q   <= err_n;
            code_q  <= code_n;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        floor_n = floor_q;
        move_n  = move_q;
        // err is recomputed every cycle, so a pulse never outlives its cause
        err_n   = 1'b0;
        code_n  = CODE_NONE;

        unique case (state_q)
            IDLE: begin
                move_n = 1'b0;
                if (estop) begin
                    // paused: nothing changes
                end else if (door_open) begin
                    floor_n = cur_floor;
                    cnt_n   = HOLD_LOAD;
                    state_n = HOLD;
                end else if (floor_bad || (dir == 2'b11)) begin
                    err_n  = 1'b1;
                    code_n = CODE_ILLEGAL;
                end else if (dir == DIR_STOP) begin
                    floor_n = cur_floor;
                end else if (dir == DIR_UP) begin
                    if (cur_floor < TOP_FLOOR) begin
                        floor_n = cur_floor + FLOOR_W'(1);
                        move_n  = 1'b1;
                        cnt_n   = MOVE_LOAD;
                        state_n = MOVE;
                    end else begin
                        err_n  = 1'b1;
                        code_n = CODE_TOP;
                    end
                end else begin
                    // only DIR_DOWN remains
                    if (cur_floor > BOTTOM_FLOOR) begin
                        floor_n = cur_floor - FLOOR_W'(1);
                        move_n  = 1'b1;
                        cnt_n   = MOVE_LOAD;
                        state_n = MOVE;
                    end else begin
                        err_n  = 1'b1;
                        code_n = CODE_BOTTOM;
                    end
                end
            end

            MOVE: begin
                // door_open and dir are deliberately not looked at here
                if (estop) begin
                    // counter, move and target all frozen
                end else if (!cnt_zero) begin
                    cnt_n = cnt_q - CNT_W'(1);
                end else begin
                    move_n  = 1'b0;
                    floor_n = cur_floor;
                    cnt_n   = HOLD_LOAD;
                    state_n = HOLD;
                end
            end

            HOLD: begin
                if (estop) begin
                    // dwell paused
                end else if (door_open) begin
                    cnt_n = HOLD_LOAD;
                end else if (!cnt_zero) begin
                    cnt_n = cnt_q - CNT_W'(1);
                end else begin
                    state_n = IDLE;
                end
            end

            default: begin
                state_n = IDLE;
                move_n  = 1'b0;
                cnt_n   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs (straight from registers)
    // ------------------------------------------------------------------
    always_comb begin
        next_floor = floor_q;
        move       = move_q;
        busy       = busy_q;
        err        = err_q;
        err_code   = code_q;
    end

    // DIR_DOWN documents the encoding; the decode falls through to it
    logic unused_ok;
    assign unused_ok = (dir == DIR_DOWN);

endmodule

// File: tb/tb_lift_stepper.sv
module tb_lift_stepper;

    localparam int NF = 7;
    localparam int FW = 3;
    localparam int MC = 4;
    localparam int HC = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          door_open;
    logic          estop;
    logic [FW-1:0] cur_floor;
    logic [1:0]    dir;
    logic [FW-1:0] next_floor;
    logic          move;
    logic          busy;
    logic          err;
    logic [1:0]    err_code;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    lift_stepper #(
        .NUM_FLOORS (NF),
        .FLOOR_W    (FW),
        .MOVE_CYCLES(MC),
        .HOLD_CYCLES(HC),
        .CNT_W      (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .door_open (door_open),
        .estop     (estop),
        .cur_floor (cur_floor),
        .dir       (dir),
        .next_floor(next_floor),
        .move      (move),
        .busy      (busy),
        .err       (err),
        .err_code  (err_code)
    );

    typedef struct {
        logic       rst;
        logic       door;
        logic       stop;
        logic [2:0] cur;
        logic [1:0] d;
        logic [2:0] e_nf;
        logic       e_mv;
        logic       e_busy;
        logic       e_err;
        logic [1:0] e_code;
    } vec_t;

    vec_t vecs [0:18];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // advance one clock and sample just after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; door_open = 1'b0; estop = 1'b0; dir = 2'b00;
        step();
        reset = 1'b0;
    endtask

    initial begin
        int mv_cnt, hold_cnt, rises, last, exp_nf;
        bit nf_ok, prev_mv, seen;

        reset = 1'b1; door_open = 1'b0; estop = 1'b0; cur_floor = 3'd3; dir = 2'b00;

        //          rst  door stop cur  dir     nf  mv busy err code
        vecs[0]  = '{1, 0, 0, 3'd3, 2'b00, 3'd1, 0, 0, 0, 2'b00};
        vecs[1]  = '{0, 0, 0, 3'd3, 2'b10, 3'd4, 1, 1, 0, 2'b00};
        vecs[2]  = '{0, 0, 0, 3'd3, 2'b00, 3'd4, 1, 1, 0, 2'b00};
        vecs[3]  = '{0, 0, 0, 3'd3, 2'b00, 3'd4, 1, 1, 0, 2'b00};
        vecs[4]  = '{0, 0, 0, 3'd3, 2'b00, 3'd4, 1, 1, 0, 2'b00};
        vecs[5]  = '{0, 0, 0, 3'd4, 2'b00, 3'd4, 0, 1, 0, 2'b00};
        vecs[6]  = '{0, 0, 0, 3'd4, 2'b00, 3'd4, 0, 1, 0, 2'b00};
        vecs[7]  = '{0, 0, 0, 3'd4, 2'b00, 3'd4, 0, 0, 0, 2'b00};
        vecs[8]  = '{0, 0, 0, 3'd7, 2'b10, 3'd4, 0, 0, 1, 2'b01};
        vecs[9]  = '{0, 0, 0, 3'd7, 2'b10, 3'd4, 0, 0, 1, 2'b01};
        vecs[10] = '{0, 0, 0, 3'd1, 2'b01, 3'd4, 0, 0, 1, 2'b10};
        vecs[11] = '{0, 0, 0, 3'd3, 2'b11, 3'd4, 0, 0, 1, 2'b11};
        vecs[12] = '{0, 0, 0, 3'd0, 2'b00, 3'd4, 0, 0, 1, 2'b11};
        vecs[13] = '{0, 0, 0, 3'd3, 2'b00, 3'd3, 0, 0, 0, 2'b00};
        vecs[14] = '{0, 1, 0, 3'd3, 2'b00, 3'd3, 0, 1, 0, 2'b00};
        vecs[15] = '{0, 1, 0, 3'd3, 2'b00, 3'd3, 0, 1, 0, 2'b00};
        vecs[16] = '{0, 0, 0, 3'd3, 2'b00, 3'd3, 0, 1, 0, 2'b00};
        vecs[17] = '{0, 0, 0, 3'd3, 2'b00, 3'd3, 0, 0, 0, 2'b00};
        vecs[18] = '{0, 1, 1, 3'd2, 2'b10, 3'd3, 0, 0, 0, 2'b00};

        for (int i = 0; i < 19; i++) begin
            reset = vecs[i].rst; door_open = vecs[i].door; estop = vecs[i].stop;
            cur_floor = vecs[i].cur; dir = vecs[i].d;
            step();
            check($sformatf("v%0d next_floor", i), int'(next_floor), int'(vecs[i].e_nf));
            check($sformatf("v%0d move", i),       int'(move),       int'(vecs[i].e_mv));
            check($sformatf("v%0d busy", i),       int'(busy),       int'(vecs[i].e_busy));
            check($sformatf("v%0d err", i),        int'(err),        int'(vecs[i].e_err));
            check($sformatf("v%0d err_code", i),   int'(err_code),   int'(vecs[i].e_code));
        end

        // DOWN step from 5 with a 3-cycle estop in the middle of MOVE
        do_reset();
        cur_floor = 3'd5; dir = 2'b01;
        mv_cnt = 0; nf_ok = 1'b1; seen = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (move) begin
                mv_cnt++;
                if (next_floor != 3'd4) nf_ok = 1'b0;
            end else if (i > 1 && !busy) begin
                seen = 1'b1;
                break;
            end
            dir = 2'b00;
            estop = (i >= 2 && i <= 4);
        end
        estop = 1'b0;
        check("estop move length", mv_cnt, MC + 3);
        check("estop target held", int'(nf_ok), 1);
        check("estop reached idle", int'(seen), 1);
        check("estop rest floor", int'(next_floor), 5);

        // door held for 5 cycles in HOLD extends the dwell to 5+HC
        do_reset();
        cur_floor = 3'd2; dir = 2'b10;
        seen = 1'b0; hold_cnt = 0; prev_mv = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            step();
            dir = 2'b00;
            if (prev_mv && !move) begin
                seen = 1'b1;
                break;
            end
            prev_mv = move;
        end
        check("door reached hold", int'(seen), 1);
        seen = 1'b0;
        for (int i = 0; i <= 40; i++) begin
            if (!busy) begin
                seen = 1'b1;
                break;
            end
            hold_cnt++;
            door_open = (i < 5);
            step();
        end
        door_open = 1'b0;
        check("door hold length", hold_cnt, 5 + HC);
        check("door hold ended", int'(seen), 1);

        // door open in IDLE with UP requested: never moves
        door_open = 1'b1; dir = 2'b10; cur_floor = 3'd2;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (move) seen = 1'b1;
        end
        check("door blocks move", int'(seen), 0);
        check("door keeps busy", int'(busy), 1);
        door_open = 1'b0; dir = 2'b00;

        // reset in the 2nd MOVE cycle aborts the step
        do_reset();
        cur_floor = 3'd3; dir = 2'b10;
        step();
        check("pre-reset move", int'(move), 1);
        dir = 2'b00;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("abort move", int'(move), 0);
        check("abort next_floor", int'(next_floor), 1);
        check("abort busy", int'(busy), 0);
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (busy) seen = 1'b1;
        end
        check("abort no hold", int'(seen), 0);

        // continuous UP from floor 1, tracker following next_floor
        reset = 1'b1; cur_floor = 3'd1; dir = 2'b00;
        step();
        reset = 1'b0; dir = 2'b10;
        rises = 0; last = 0; exp_nf = 2; prev_mv = 1'b0;
        for (int i = 1; i <= 120 && rises < 6; i++) begin
            step();
            cur_floor = next_floor;
            if (move && !prev_mv) begin
                check($sformatf("climb target %0d", rises), int'(next_floor), exp_nf);
                if (rises > 0) check($sformatf("climb period %0d", rises), i - last, 1 + MC + HC);
                last = i;
                rises++;
                exp_nf++;
            end
            prev_mv = move;
        end
        check("climb steps", rises, 6);
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step();
            cur_floor = next_floor;
            if (err) begin
                seen = 1'b1;
                break;
            end
        end
        check("top error seen", int'(seen), 1);
        check("top error code", int'(err_code), 1);
        step();
        check("top error repeats", int'(err), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/lift_stepper.md
# lift_stepper

Parametrised per-car motion stepper for the elevator controller: for an N-floor shaft it converts the scheduler's requested direction into one-floor moves. Each move has a fixed travel time and is followed by a fixed dwell. It sits between the direction scheduler (source of `dir`) and the floor tracker and motor driver (consumers of `next_floor` and `move`). Compared with the fixed 7-floor stepper, it adds:
- floor-count and counter-width generics;
- emergency-stop pause and resume;
- door-extended dwell;
- error reporting in hardware instead of simulation messages.

## Interface
Parameters:
- `NUM_FLOORS`, 7, number of floors; floors are numbered 1..NUM_FLOORS.
- `FLOOR_W`, 3, floor-number width; must satisfy 2^FLOOR_W > NUM_FLOORS.
- `MOVE_CYCLES`, 100, clock cycles `move` stays high per one-floor step; must be ≥1.
- `HOLD_CYCLES`, 10, clock cycles of dwell after a step or door event; must be ≥1.
- `CNT_W`, 32, counter width; must satisfy MOVE_CYCLES, HOLD_CYCLES < 2^CNT_W.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `reset`  in  1  reset, synchronous, active-high.
- `door_open`  in  1  door is not fully closed.
- `estop`  in  1  emergency stop, level-sensitive.
- `cur_floor`  in  FLOOR_W  floor reported by the tracker.
- `dir`  in  2  requested direction: STOP=00, UP=10, DOWN=01, illegal=11.
- `next_floor`  out  FLOOR_W  target floor while `move`=1; otherwise the floor the car rests at.
- `move`  out  1  motor command, high during a step.
- `busy`  out  1  high whenever the state is not IDLE.
- `err`  out  1  one-cycle error pulse.
- `err_code`  out  2  cause of the error, valid while `err`=1: 01=UP at top, 10=DOWN at bottom, 11=illegal `dir` or `cur_floor` out of range; 00 otherwise.

## Operation
- States are IDLE, MOVE and HOLD. A single down-counter `cnt` of CNT_W bits serves both MOVE and HOLD.
- **Reset values:** state=IDLE, cnt=0, next_floor=1, move=0, busy=0, err=0, err_code=00. Reset takes priority over every other input, including in mid-move; no step completes after reset.
- **IDLE, evaluated each cycle in this priority order:**
  1. `estop`=1: stay in IDLE, no action.
  2. `door_open`=1: next_floor←cur_floor, cnt←HOLD_CYCLES−1, go to HOLD.
  3. `cur_floor`==0 or `cur_floor`>NUM_FLOORS, or `dir`=11: err pulse with code 11, stay in IDLE.
  4. `dir`=STOP: next_floor←cur_floor, stay in IDLE.
  5. `dir`=UP and cur_floor<NUM_FLOORS: next_floor←cur_floor+1, move←1, cnt←MOVE_CYCLES−1, go to MOVE. If cur_floor==NUM_FLOORS: err pulse with code 01, stay in IDLE.
  6. `dir`=DOWN and cur_floor>1: next_floor←cur_floor−1, move←1, cnt←MOVE_CYCLES−1, go to MOVE. If cur_floor==1: err pulse with code 10, stay in IDLE.
- **MOVE:**
  - `estop`=1 freezes cnt; move and next_floor hold their values. Counting resumes on the cycle after `estop` deasserts.
  - Otherwise, if cnt≠0: cnt←cnt−1.
  - If cnt==0: move←0, next_floor←cur_floor, cnt←HOLD_CYCLES−1, go to HOLD.
  - `door_open` and `dir` are ignored in MOVE.
- **HOLD:**
  - `estop`=1 freezes cnt.
  - Otherwise, `door_open`=1 reloads cnt←HOLD_CYCLES−1, which extends the dwell.
  - Otherwise, if cnt≠0: cnt←cnt−1.
  - Otherwise (cnt==0): go to IDLE.
- **Arithmetic:** next_floor ±1 is computed at FLOOR_W bits. The range checks guarantee it never wraps.
- **Error pulses:** `err` is never high for two consecutive cycles from a single event. While the error condition persists in IDLE, `err` pulses every cycle.

## Timing
- Outputs are registered: a decision taken on edge k is visible after edge k.
- A step, from IDLE with dir=UP and no estop or door: move is high for exactly MOVE_CYCLES cycles, then busy stays high for HOLD_CYCLES cycles of HOLD, then the block is in IDLE.
- Minimum period between successive move rising edges is 1+MOVE_CYCLES+HOLD_CYCLES cycles.
- Each estop cycle during MOVE or HOLD lengthens that phase by exactly one cycle.
- `busy` is registered as (next state ≠ IDLE), so it rises in the same cycle as `move`.
- When an input changes in the same cycle as the IDLE decision, the value sampled on that edge is used. There is no input synchronisation; callers provide synchronous inputs.

## Test plan
Use MOVE_CYCLES=4, HOLD_CYCLES=2, NUM_FLOORS=7.
1. Reset, then cur_floor=3, dir=UP → next_floor=4 and move=1 for 4 cycles; then move=0 and next_floor=cur_floor; busy=1 for 2 more cycles; then IDLE.
2. cur_floor=7, dir=UP → err=1 with err_code=01 each cycle, move stays 0. cur_floor=1, dir=DOWN → err_code=10. dir=11 → err_code=11.
3. Start a DOWN step from floor 5, then assert estop for 3 cycles mid-move → next_floor=4 throughout; move is high for 7 cycles in total.
4. Hold door_open=1 in HOLD for 5 cycles → HOLD lasts 5+2 cycles; no move while door_open=1 in IDLE.
5. Assert reset in the 2nd MOVE cycle → next cycle move=0, next_floor=1, busy=0, and no HOLD follows.
6. Hold dir=UP continuously from floor 1 with cur_floor tracking next_floor → next_floor steps 2..7 with exactly 7 cycles between move rising edges; at floor 7 IDLE raises err_code=01.
